// File: rtl/match_frame_counter_if.sv
// Handshake bundle between the upstream detector/consumer and match_frame_counter.
// The master drives the match pulse and framing controls, and the slave returns the frame result.
interface match_frame_counter_if #(
  parameter int CNT_W = 4
) ();
  logic             z;
  logic             start;
  logic             stop;
  logic             result_ack;
  logic [CNT_W-1:0] count;
  logic             result_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output z, start, stop, result_ack,
    input  count, result_valid, overrun, busy
  );

  modport slave (
    input  z, start, stop, result_ack,
    output count, result_valid, overrun, busy
  );
endinterface

// File: rtl/match_frame_counter.sv
// Counts 1-0-1 detector match pulses over back-to-back frames of FRAME_LEN samples.
// Each result is published with a valid/ack handshake and a sticky overrun flag.
module match_frame_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  match_frame_counter_if.slave bus
);

  localparam int               BIT_W   = $clog2(FRAME_LEN);
  localparam logic [BIT_W-1:0] LAST    = BIT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               busy_q;
  logic [CNT_W-1:0]   acc_sat;
  logic               frame_done;

  // The accumulator holds at its maximum once it is full instead of wrapping.
  assign acc_sat    = (acc_q == CNT_MAX) ? CNT_MAX : acc_q + CNT_W'(bus.z);
  assign frame_done = (state_q == RUN) && (bit_q == LAST);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_d = state_q;
    bit_d   = bit_q;
    acc_d   = acc_q;
    count_d = count_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = RUN;
          bit_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (frame_done) begin
          // Completing edge publishes even when stop is high, then stop takes effect.
          count_d = acc_sat;
          valid_d = 1'b1;
          if (valid_q && !bus.result_ack) ovr_d = 1'b1;
          acc_d   = '0;
          bit_d   = '0;
          if (bus.stop) state_d = IDLE;
        end else if (bus.stop) begin
          state_d = IDLE;
          acc_d   = '0;
          bit_d   = '0;
        end else begin
          acc_d = acc_sat;
          bit_d = bit_q + BIT_W'(1);
        end
      end
    endcase

    if (valid_q && bus.result_ack && !frame_done) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      busy_q  <= (state_d == RUN);
    end
  end

  assign bus.count        = count_q;
  assign bus.result_valid = valid_q;
  assign bus.overrun      = ovr_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/match_frame_counter.md
MATCH_FRAME_COUNTER -- requirements
Module: match_frame_counter

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 16, giving the number of z samples per frame (legal range 2..2^16).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the match count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port z, input, 1 bit: per-cycle match pulse from the upstream 1-0-1 sequence detector.
REQ-006 The block SHALL have port start, input, 1 bit: request to begin framing.
REQ-007 The block SHALL have port stop, input, 1 bit: request to abort framing.
REQ-008 The block SHALL have port result_ack, input, 1 bit: consumer acknowledge of the current result.
REQ-009 The block SHALL have port count, output, CNT_W bits: match count of the last completed frame.
REQ-010 The block SHALL have port result_valid, output, 1 bit: count holds an unconsumed result.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag; an unconsumed result was overwritten.
REQ-012 The block SHALL have port busy, output, 1 bit: high while in state RUN.

Function
REQ-013 The block SHALL implement a two-state FSM, IDLE and RUN, with a bit counter (ceil(log2(FRAME_LEN)) bits) and a CNT_W-bit accumulator.
REQ-014 In IDLE, start=1 at a rising edge SHALL move the FSM to RUN and clear the bit counter and accumulator; z on that edge is not counted.
REQ-015 In RUN, every rising edge SHALL sample z as one frame sample: accumulator <= accumulator + z, saturating at 2^CNT_W-1.
REQ-016 On the edge sampling the FRAME_LEN-th sample (bit counter = FRAME_LEN-1), count SHALL load the saturated value accumulator + z, result_valid SHALL be set to 1, and the accumulator and bit counter SHALL be cleared.
REQ-017 After a frame completes, the FSM SHALL stay in RUN and begin the next frame on the following edge, with no gap cycle.
REQ-018 start while in RUN SHALL be ignored.
REQ-019 stop=1 in RUN with the bit counter not at FRAME_LEN-1 SHALL return the FSM to IDLE; the partial frame SHALL be discarded, z on that edge is not counted, and count and result_valid SHALL be unchanged.
REQ-020 stop=1 on a frame-completing edge SHALL publish that frame per REQ-016, then enter IDLE.
REQ-021 stop in IDLE SHALL be ignored; start and stop both high in IDLE SHALL leave the FSM in IDLE.
REQ-022 result_ack=1 while result_valid=1 with no frame completing on that edge SHALL clear result_valid on that edge.
REQ-023 result_ack while result_valid=0 SHALL have no effect.
REQ-024 A frame completing while result_valid=1 and result_ack=0 SHALL overwrite count, keep result_valid=1, and set overrun=1.
REQ-025 A frame completing while result_valid=1 and result_ack=1 SHALL load the new count, keep result_valid=1, and leave overrun unchanged.
REQ-026 overrun SHALL stay set until rst; no other input clears it.
REQ-027 busy SHALL be a registered copy of state: 1 in RUN, 0 in IDLE.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, clear the bit counter and accumulator, and set count=0, result_valid=0, overrun=0, busy=0, overriding all other inputs.
REQ-029 rst mid-frame SHALL discard the partial frame; framing resumes only on a later start.

Verification (FRAME_LEN=16, CNT_W=4)
REQ-030 The bench SHALL cover: rst; start pulse; z=1 on frame samples 3, 6 and 11 only -> after the 16th sample edge, count=3, result_valid=1, busy=1.
REQ-031 The bench SHALL cover: result_ack held 0 across two frames of 2 then 5 matches -> after frame 2, count=5, result_valid=1, overrun=1; overrun still 1 after a later ack.
REQ-032 The bench SHALL cover: z=1 for all 16 samples -> count=15 (saturated), result_valid=1.
REQ-033 The bench SHALL cover: stop after sample 7 with 2 matches counted -> busy=0, result_valid remains 0; a new start then 16 samples with 1 match -> count=1.
REQ-034 The bench SHALL cover: result_ack=1 on the same edge a frame completes with 4 matches, while valid -> count=4, result_valid=1, overrun=0.
REQ-035 The bench SHALL cover: rst asserted at sample 9 -> the next edge gives count=0, result_valid=0, overrun=0, busy=0; z activity without start produces no result.
